line_scan_sequencer: RTL and testbench
======================================

// Module: line_scan_sequencer
//
// PURPOSE
//   Upstream driver for the 4-to-16 line decoder. It steps a 4-bit line address and
//   enable through all 16 lines, holding each line for a programmable dwell time.
//   At the end of each dwell it samples a single return/sense line. Any hit is
//   reported as a 4-bit index through a valid/ready handshake.
//   Typical use: keypad or sensor-matrix scanning, with sel_addr/sel_en wired to
//   decoder a/en.
//
// PARAMETERS
//   DWELL        8  clock cycles each line stays enabled (legal range 2..256)
//   STOP_ON_HIT  0  1: end the sweep after the first accepted hit; 0: resume at next line
//   CONTINUOUS   0  1: wrap from line 15 to line 0 forever; 0: single sweep per start
//
// PORTS
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  begin sweep at line 0; sampled only in IDLE
//   stop        in   1  abort sweep; has priority over start
//   sense       in   1  return line from the selected decoder path; already synchronous to clk
//   sel_addr    out  4  line address to the decoder a[3:0]
//   sel_en      out  1  decoder enable
//   busy        out  1  high in any state except IDLE
//   hit_valid   out  1  hit report valid
//   hit_index   out  4  line that produced the hit
//   hit_ready   in   1  consumer accepts the hit
//   sweep_done  out  1  one-cycle pulse when a sweep ends normally
//
// BEHAVIOUR
//   Reset values: sel_addr=0, sel_en=0, busy=0, hit_valid=0, hit_index=0, sweep_done=0.
//     All outputs are registered.
//   Asserting rst mid-operation clears every output immediately (asynchronously).
//     Any pending hit is discarded.
//   States:
//     IDLE   -> DRIVE   on start && !stop; sel_addr=0 and dwell counter=0 in the next cycle.
//     DRIVE  : sel_en=1. The dwell counter runs 0..DWELL-1.
//              sense is sampled only at the edge that ends dwell DWELL-1; earlier cycles are settling time.
//              sense=1 at the sample  -> REPORT; hit_index=sel_addr, hit_valid=1, sel_en=0.
//              sense=0, line <15      -> sel_addr+1, counter=0, sel_en stays high (no gap).
//              sense=0, line 15       -> CONTINUOUS=1: sel_addr=0, stay in DRIVE.
//                                        CONTINUOUS=0: IDLE with sweep_done=1 for one cycle.
//     REPORT : sel_en=0. hit_valid and hit_index hold stable until hit_valid && hit_ready.
//              The transfer completes on that edge; hit_valid=0 next cycle.
//              After the transfer:
//                STOP_ON_HIT=1                 -> IDLE, sweep_done=1.
//                line <15                      -> DRIVE at sel_addr+1.
//                line 15, CONTINUOUS=1         -> DRIVE at line 0.
//                line 15, CONTINUOUS=0         -> IDLE, sweep_done=1.
//   stop in DRIVE or REPORT: go to IDLE next cycle with sel_en=0, no sweep_done.
//     If stop coincides with a completing transfer, the transfer counts, then IDLE.
//   start while busy is ignored.
//   sel_addr changes only while sel_en=0 or at a dwell boundary, never mid-dwell.
//   Timing, no-hit single sweep: sel_en high for exactly 16*DWELL consecutive cycles,
//     followed by sweep_done with busy=0 in the same cycle.
//   Dwell counter width is $clog2(DWELL). It wraps only through the explicit reset to 0.
//
// TESTING
//   1. DWELL=4, sense=0, pulse start
//        -> sel_addr 0..15 for 4 cycles each, sel_en high for 64 cycles, then sweep_done=1 for 1 cycle.
//   2. sense=1 only at the sample edge of line 5, hit_ready low for 3 cycles then high
//        -> hit_valid=1 and hit_index=5 stable throughout; sel_en=0; DRIVE resumes at line 6.
//   3. sense=1 during dwell cycles 0..2 of line 3, 0 on the last dwell cycle
//        -> no hit; the sweep continues uninterrupted.
//   4. STOP_ON_HIT=1 with a hit on line 15, and separately CONTINUOUS=1 with no hits
//        -> first: IDLE plus sweep_done after the handshake; second: wrap 15->0, sweep_done never asserted.
//   5. stop at line 9, mid-dwell
//        -> sel_en=0 and busy=0 next cycle, no sweep_done.
//      start and stop together in IDLE -> remains IDLE.
//   6. rst asserted mid-cycle in REPORT
//        -> all outputs 0 before the next clock edge; after release, IDLE until start.

Source files
------------

// File: rtl/line_scan_sequencer.sv
// rtl/line_scan_sequencer.sv - steps a 4-to-16 decoder through all lines, samples sense, reports hits
//
// Purpose: drives sel_addr/sel_en into a 4-to-16 line decoder. Each of the 16 lines
//   is held for DWELL cycles. The sense return is sampled on the edge that ends each
//   dwell. A hit is offered on a valid/ready handshake.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep at line 0 (IDLE only)
//   stop       in   abort the sweep (wins over start)
//   sense      in   synchronous return line of the selected path
//   sel_addr   out  [3:0] decoder address
//   sel_en     out  decoder enable
//   busy       out  high whenever not IDLE
//   hit_valid  out  hit report valid
//   hit_index  out  [3:0] line that produced the hit
//   hit_ready  in   consumer accepts the hit
//   sweep_done out  one-cycle pulse on normal sweep end
module line_scan_sequencer #(
  parameter int DWELL       = 8,
  parameter bit STOP_ON_HIT = 1'b0,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       sense,
  output logic [3:0] sel_addr,
  output logic       sel_en,
  output logic       busy,
  output logic       hit_valid,
  output logic [3:0] hit_index,
  input  logic       hit_ready,
  output logic       sweep_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, REPORT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    sel_addr_n, hit_index_n;
  logic          sel_en_n, hit_valid_n, sweep_done_n;
  logic          last_line;

  assign last_line = (sel_addr == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_addr   <= 4'd0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      hit_valid  <= 1'b0;
      hit_index  <= 4'd0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel_addr   <= sel_addr_n;
      sel_en     <= sel_en_n;
      busy       <= (state_n != IDLE);
      hit_valid  <= hit_valid_n;
      hit_index  <= hit_index_n;
      sweep_done <= sweep_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_addr_n   = sel_addr;
    sel_en_n     = sel_en;
    hit_valid_n  = hit_valid;
    hit_index_n  = hit_index;
    sweep_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n    = DRIVE;
          sel_addr_n = 4'd0;
          cnt_n      = '0;
          sel_en_n   = 1'b1;
        end
      end
      DRIVE: begin
        if (stop) begin
          state_n  = IDLE;
          sel_en_n = 1'b0;
        end else if (cnt != LAST) begin
          // settling cycles: sense is ignored until the last dwell cycle
          cnt_n = cnt + 1'b1;
        end else if (sense) begin
          state_n     = REPORT;
          sel_en_n    = 1'b0;
          hit_valid_n = 1'b1;
          hit_index_n = sel_addr;
        end else if (!last_line) begin
          // move to the next line with no enable gap
          sel_addr_n = sel_addr + 4'd1;
          cnt_n      = '0;
        end else if (CONTINUOUS) begin
          sel_addr_n = 4'd0;
          cnt_n      = '0;
        end else begin
          state_n      = IDLE;
          sel_en_n     = 1'b0;
          sweep_done_n = 1'b1;
        end
      end
      REPORT: begin
        if (hit_valid && hit_ready) begin
          // transfer completes this edge even if stop is also asserted
          hit_valid_n = 1'b0;
          if (stop) begin
            state_n = IDLE;
          end else if (STOP_ON_HIT || (last_line && !CONTINUOUS)) begin
            state_n      = IDLE;
            sweep_done_n = 1'b1;
          end else begin
            state_n    = DRIVE;
            sel_addr_n = last_line ? 4'd0 : sel_addr + 4'd1;
            cnt_n      = '0;
            sel_en_n   = 1'b1;
          end
        end else if (stop) begin
          state_n     = IDLE;
          hit_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_scan_sequencer.sv
// tb/tb_line_scan_sequencer.sv - directed self-checking bench for line_scan_sequencer
module tb_line_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sense = 1'b0;
  logic       hit_ready = 1'b0;
  logic [3:0] a_addr, b_addr, c_addr, a_idx, b_idx, c_idx;
  logic       a_en, a_busy, a_hv, a_done;
  logic       b_en, b_busy, b_hv, b_done;
  logic       c_en, c_busy, c_hv, c_done;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  line_scan_sequencer #(.DWELL(4), .STOP_ON_HIT(1'b0), .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sense(sense),
    .sel_addr(a_addr), .sel_en(a_en), .busy(a_busy), .hit_valid(a_hv),
    .hit_index(a_idx), .hit_ready(hit_ready), .sweep_done(a_done));

  line_scan_sequencer #(.DWELL(4), .STOP_ON_HIT(1'b1), .CONTINUOUS(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sense(sense),
    .sel_addr(b_addr), .sel_en(b_en), .busy(b_busy), .hit_valid(b_hv),
    .hit_index(b_idx), .hit_ready(hit_ready), .sweep_done(b_done));

  line_scan_sequencer #(.DWELL(4), .STOP_ON_HIT(1'b0), .CONTINUOUS(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sense(sense),
    .sel_addr(c_addr), .sel_en(c_en), .busy(c_busy), .hit_valid(c_hv),
    .hit_index(c_idx), .hit_ready(hit_ready), .sweep_done(c_done));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_addr", a_addr, 0);
    chk("rst_en", a_en, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_hv", a_hv, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_done", a_done, 0);
    rst = 1'b0;
    tick();

    // single no-hit sweep, with a stray start mid-sweep
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("t1_en", a_en, 1);
      chk("t1_addr", a_addr, i / 4);
      chk("t1_done", a_done, 0);
      start = (i == 20);
      tick();
    end
    chk("t1_end_en", a_en, 0);
    chk("t1_end_done", a_done, 1);
    chk("t1_end_busy", a_busy, 0);
    tick();
    chk("t1_done_pulse", a_done, 0);

    // settling glitch on line 3, real hit on line 5
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("t23_en", a_en, 1);
      chk("t23_addr", a_addr, i / 4);
      chk("t23_hv", a_hv, 0);
      sense = ((i >= 12 && i <= 14) || i == 23);
      tick();
    end
    sense = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hv", a_hv, 1);
      chk("t2_idx", a_idx, 5);
      chk("t2_en", a_en, 0);
      chk("t2_busy", a_busy, 1);
      hit_ready = (i == 2);
      tick();
    end
    hit_ready = 1'b0;
    chk("t2_hv_clr", a_hv, 0);
    chk("t2_resume_en", a_en, 1);
    chk("t2_resume_addr", a_addr, 6);

    // stop mid-dwell on line 9
    repeat (13) tick();
    chk("t5_addr", a_addr, 9);
    chk("t5_en", a_en, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t5_en_off", a_en, 0);
    chk("t5_busy_off", a_busy, 0);
    chk("t5_no_done", a_done, 0);
    tick();
    chk("t5_no_done2", a_done, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t5_ss_busy", a_busy, 0);
    chk("t5_ss_en", a_en, 0);
    tick();
    chk("t5_ss_busy2", a_busy, 0);

    // hit on line 15: STOP_ON_HIT ends sweep, CONTINUOUS wraps
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    hit_ready = 1'b1;
    repeat (63) tick();
    sense = 1'b1; tick(); sense = 1'b0;
    chk("t4a_hv", b_hv, 1);
    chk("t4a_idx", b_idx, 15);
    chk("t4a_addr", b_addr, 15);
    chk("t4a_en", b_en, 0);
    chk("t4a_c_idx", c_idx, 15);
    tick();
    chk("t4a_hv_clr", b_hv, 0);
    chk("t4a_busy", b_busy, 0);
    chk("t4a_done", b_done, 1);
    chk("t4a_en_off", b_en, 0);
    chk("t4a_c_busy", c_busy, 1);
    chk("t4a_c_en", c_en, 1);
    chk("t4a_c_addr", c_addr, 0);
    chk("t4a_c_hv", c_hv, 0);
    chk("t4a_c_done", c_done, 0);
    tick();
    chk("t4a_done_pulse", b_done, 0);
    hit_ready = 1'b0;

    // continuous sweep with no hits wraps 15 -> 0
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      chk("t4b_en", c_en, 1);
      chk("t4b_addr", c_addr, (i / 4) % 16);
      chk("t4b_done", c_done, 0);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t4b_stop_busy", c_busy, 0);
    chk("t4b_stop_done", c_done, 0);

    // asynchronous reset while a hit is pending
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    sense = 1'b1; tick(); sense = 1'b0;
    chk("t6_hv", a_hv, 1);
    chk("t6_idx", a_idx, 1);
    chk("t6_en", a_en, 0);
    #3 rst = 1'b1;
    #1;
    chk("t6_addr", a_addr, 0);
    chk("t6_en0", a_en, 0);
    chk("t6_busy0", a_busy, 0);
    chk("t6_hv0", a_hv, 0);
    chk("t6_idx0", a_idx, 0);
    chk("t6_done0", a_done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_busy", a_busy, 0);
    chk("t6_idle_en", a_en, 0);
    chk("t6_idle_hv", a_hv, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_start_busy", a_busy, 1);
    chk("t6_start_en", a_en, 1);
    chk("t6_start_addr", a_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
